// File: rtl/jtag_scan_master.sv
// jtag_scan_master
// Host-side IEEE 1149.1 scan engine. It accepts IR-scan, DR-scan and TAP-reset
// commands on a valid/ready port and walks the target TAP on TCK/TMS/TDI.
// It captures TDO bit by bit and returns the captured word on a valid/ready
// response port. Only one command is outstanding at a time.
module jtag_scan_master #(
  parameter int CLK_DIV = 4,   // TCK half-period in clk cycles (>= 1)
  parameter int MAX_LEN = 64   // longest scan in bits
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_is_ir,
  input  logic [6:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [6:0]       MAX_LEN_C = 7'(MAX_LEN);

  // Controller states
  localparam logic [2:0] ST_INIT  = 3'd0;  // power-on TAP reset walk
  localparam logic [2:0] ST_IDLE  = 3'd1;  // waiting for a command
  localparam logic [2:0] ST_PRE   = 3'd2;  // RTI -> Capture, then Capture -> Shift
  localparam logic [2:0] ST_SHIFT = 3'd3;  // one TCK per scan bit
  localparam logic [2:0] ST_POST  = 3'd4;  // Exit1 -> Update -> RTI
  localparam logic [2:0] ST_RESP  = 3'd5;  // holding the response
  localparam logic [2:0] ST_RST   = 3'd6;  // commanded TAP reset walk

  // TMS bits that follow the first TMS=1 of each walk. The LSB is used first.
  localparam logic [4:0] SEQ_RESET  = 5'b01111;  // 1,1,1,1 then 0 into RTI
  localparam logic [4:0] SEQ_PRE_DR = 5'b00000;  // 0 -> Capture-DR, 0 -> Shift-DR
  localparam logic [4:0] SEQ_PRE_IR = 5'b00001;  // 1 -> Select-IR, 0, 0
  localparam logic [4:0] SEQ_POST   = 5'b00000;  // 0 from Update into RTI

  // Number of TCK periods spent in each fixed walk
  localparam logic [6:0] N_RESET  = 7'd6;
  localparam logic [6:0] N_PRE_DR = 7'd3;
  localparam logic [6:0] N_PRE_IR = 7'd4;
  localparam logic [6:0] N_POST   = 7'd2;

  logic [2:0]         state_q, state_d;
  logic [DIV_W-1:0]   div_q,   div_d;    // clk count inside a TCK half-period
  logic               tck_q,   tck_d;
  logic               tms_q,   tms_d;
  logic [4:0]         seq_q,   seq_d;    // TMS bits still to be sent in a walk
  logic [6:0]         cnt_q,   cnt_d;    // TCK periods left in the current state
  logic [6:0]         len_q,   len_d;    // clamped scan length
  logic [IDX_W-1:0]   bit_q,   bit_d;    // index of the bit being shifted
  logic [MAX_LEN-1:0] data_q,  data_d;   // TDI bits; bit 0 is on the pin
  logic [MAX_LEN-1:0] cap_q,   cap_d;    // captured TDO bits

  logic       running;
  logic       tick;
  logic       tck_rise;
  logic       tck_fall;
  logic [6:0] len_clamped;

  assign running = (state_q == ST_INIT) || (state_q == ST_RST) ||
                   (state_q == ST_PRE)  || (state_q == ST_SHIFT) ||
                   (state_q == ST_POST);
  assign tick     = running && (div_q == DIV_LAST);
  assign tck_rise = tick && !tck_q;
  assign tck_fall = tick && tck_q;

  assign len_clamped = (cmd_len > MAX_LEN_C) ? MAX_LEN_C : cmd_len;

  // Next-state logic: command accept, TCK generation and the per-state TMS/TDI walk
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through this
    // block leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    div_d   = div_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    bit_d   = bit_q;
    data_d  = data_q;
    cap_d   = cap_q;

    if (running) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          // The first TMS bit of every walk is 1. TCK is low here, so TMS and
          // TDI may change now.
          cap_d  = '0;
          data_d = cmd_data;
          bit_d  = '0;
          div_d  = '0;
          len_d  = len_clamped;
          tms_d  = 1'b1;
          if (len_clamped == 7'd0) begin
            state_d = ST_RST;
            seq_d   = SEQ_RESET;
            cnt_d   = N_RESET;
          end else begin
            state_d = ST_PRE;
            seq_d   = cmd_is_ir ? SEQ_PRE_IR : SEQ_PRE_DR;
            cnt_d   = cmd_is_ir ? N_PRE_IR : N_PRE_DR;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase

    // TDO is stable before the rising edge, so it is taken on the cycle where TCK goes high
    if (tck_rise) begin
      tck_d = 1'b1;
      if (state_q == ST_SHIFT) begin
        cap_d[bit_q] = tdo;
      end
    end

    // TMS/TDI move only on a falling edge, half a period away from the target's sampling edge
    if (tck_fall) begin
      tck_d = 1'b0;
      if (cnt_q != 7'd1) begin
        cnt_d = cnt_q - 7'd1;
        if (state_q == ST_SHIFT) begin
          data_d = data_q >> 1;
          bit_d  = bit_q + IDX_W'(1);
          tms_d  = (cnt_q == 7'd2);  // the next bit is the last one and leaves Shift
        end else begin
          tms_d = seq_q[0];
          seq_d = seq_q >> 1;
        end
      end else begin
        case (state_q)
          ST_INIT: begin
            state_d = ST_IDLE;
          end
          ST_RST, ST_POST: begin
            state_d = ST_RESP;
          end
          ST_PRE: begin
            state_d = ST_SHIFT;
            cnt_d   = len_q;
            tms_d   = (len_q == 7'd1);
          end
          ST_SHIFT: begin
            state_d = ST_POST;
            cnt_d   = N_POST;
            seq_d   = SEQ_POST;
            tms_d   = 1'b1;
            data_d  = '0;  // park TDI low once the scan is done
          end
          default: ;
        endcase
      end
    end
  end

  // State registers; reset puts the controller at the start of the INIT walk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      div_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      seq_q   <= SEQ_RESET;
      cnt_q   <= N_RESET;
      len_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      cap_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments, so all registers update together from
      // the values of the previous cycle.
      state_q <= state_d;
      div_q   <= div_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_data  = cap_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = data_q[0];

endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master
// Directed bench for jtag_scan_master. The target is a behavioural IEEE 1149.1
// TAP with a 10-bit IR, a 32-bit IDCODE register and a 1-bit BYPASS register.
module tb_jtag_scan_master;

  localparam int          CLK_DIV      = 2;
  localparam int          MAX_LEN      = 64;
  localparam int          TCK_CLK      = 2 * CLK_DIV;
  localparam logic [31:0] IDCODE       = 32'h020F30DD;
  localparam logic [9:0]  IDCODE_INSTR = 10'h006;
  localparam logic [9:0]  BYPASS_INSTR = 10'h3FF;

  logic               clk       = 1'b0;
  logic               reset_n   = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_is_ir = 1'b0;
  logic [6:0]         cmd_len   = '0;
  logic [MAX_LEN-1:0] cmd_data  = '0;
  logic               rsp_ready = 1'b0;
  logic               tdo       = 1'b0;
  logic               cmd_ready;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;
  logic               tck;
  logic               tms;
  logic               tdi;

  int total = 0;
  int bad   = 0;
  int rise0 = 0;

  always #5 clk = ~clk;

  jtag_scan_master #(
    .CLK_DIV (CLK_DIV),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_is_ir (cmd_is_ir),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo)
  );

  // ---------------- target TAP model ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_e;

  tap_e        tap_q    = TLR;
  logic [9:0]  ir_q     = IDCODE_INSTR;
  logic [9:0]  ir_sr    = '0;
  logic [31:0] dr_sr    = '0;
  logic [7:0]  tms_hist = '0;
  int          rise_cnt = 0;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PA_DR;
      PA_DR:   return m ? EX2_DR : PA_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PA_IR;
      PA_IR:   return m ? EX2_IR : PA_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;  // UPD_IR
    endcase
  endfunction

  // TAP samples TMS/TDI on rising TCK
  always @(posedge tck) begin
    rise_cnt <= rise_cnt + 1;
    tms_hist <= {tms_hist[6:0], tms};
    case (tap_q)
      TLR:    ir_q  <= IDCODE_INSTR;
      CAP_DR: dr_sr <= (ir_q == BYPASS_INSTR) ? 32'h0 : IDCODE;
      SH_DR:  if (ir_q == BYPASS_INSTR) dr_sr[0] <= tdi;
              else dr_sr <= {tdi, dr_sr[31:1]};
      CAP_IR: ir_sr <= 10'h001;
      SH_IR:  ir_sr <= {tdi, ir_sr[9:1]};
      UPD_IR: ir_q  <= ir_sr;
      default: ;
    endcase
    tap_q <= tap_next(tap_q, tms);
  end

  // TAP drives TDO on falling TCK
  always @(negedge tck) begin
    tdo <= (tap_q == SH_DR) ? dr_sr[0] : (tap_q == SH_IR) ? ir_sr[0] : 1'b0;
  end

  // ---------------- checking and stimulus helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge just after reset release
  task automatic wait_init(input string tag);
    int   cycles;
    int   start;
    logic saw_rsp;
    cycles  = 0;
    start   = rise_cnt;
    saw_rsp = 1'b0;
    while (!cmd_ready && cycles < 1000) begin
      @(posedge clk); #1;
      cycles++;
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check({tag, "_cycles"}, cycles, 12 * CLK_DIV);
    check({tag, "_rises"}, rise_cnt - start, 6);
    check({tag, "_tms_seq"}, tms_hist[5:0], 6'b111110);
    check({tag, "_no_rsp"}, saw_rsp, 1'b0);
    check({tag, "_tap_rti"}, tap_q, RTI);
  endtask

  task automatic send(input string tag, input logic ir, input logic [6:0] len,
                      input logic [63:0] data);
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (!cmd_ready && waitc < 1000) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, "_ready"}, cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_is_ir = ir;
    cmd_len   = len;
    cmd_data  = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rise0     = rise_cnt;
    check({tag, "_ready_drop"}, cmd_ready, 1'b0);
  endtask

  // Entered one cycle after the handshake cycle; counts cycles until rsp_valid
  task automatic get_rsp(input string tag, input int n_tck, output logic [63:0] rdata);
    int cycles;
    cycles = 1;
    while (!rsp_valid && cycles < 4000) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, "_latency"}, cycles, n_tck * TCK_CLK + 1);
    check({tag, "_rises"}, rise_cnt - rise0, n_tck);
    rdata = rsp_data;
  endtask

  task automatic ack(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, rsp_valid, 1'b0);
    check({tag, "_ready_back"}, cmd_ready, 1'b1);
  endtask

  task automatic scan(input string tag, input logic ir, input logic [6:0] len,
                      input logic [63:0] data, input int n_tck, input logic [63:0] exp);
    logic [63:0] r;
    send(tag, ir, len, data);
    get_rsp(tag, n_tck, r);
    check({tag, "_data"}, r, exp);
    check({tag, "_tap_rti"}, tap_q, RTI);
    ack(tag);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    int          unstable;
    int          start;
    int          waitc;

    // Reset values
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 64'h0);
    check("rst_tck", tck, 1'b0);
    check("rst_tms", tms, 1'b1);
    check("rst_tdi", tdi, 1'b0);
    check("rst_busy", busy, 1'b1);

    @(negedge clk);
    reset_n = 1'b1;
    wait_init("init");
    check("idle_busy", busy, 1'b0);
    check("idle_tms", tms, 1'b0);

    // IDCODE read: 32 + 5 TCKs
    scan("idcode", 1'b0, 7'd32, 64'h0, 37, {32'h0, IDCODE});

    // Load BYPASS (IR capture pattern 0x001 comes back), then an 8-bit bypass DR scan
    scan("ir_bypass", 1'b1, 7'd10, 64'h3FF, 16, 64'h001);
    check("ir_loaded", ir_q, BYPASS_INSTR);
    scan("bypass_dr", 1'b0, 7'd8, 64'h5A, 13, 64'hB4);

    // TAP reset command: TMS 1,1,1,1,1,0 and IR back to IDCODE
    scan("tap_reset", 1'b0, 7'd0, 64'hDEAD, 6, 64'h0);
    check("tap_reset_tms", tms_hist[5:0], 6'b111110);
    check("tap_reset_ir", ir_q, IDCODE_INSTR);

    // Length 70 clamps to 64: IDCODE then the first 32 TDI bits come back
    scan("clamp", 1'b0, 7'd70, 64'h1234_5678_9ABC_DEF0, 69, 64'h9ABC_DEF0_020F_30DD);

    // Backpressure: response held for 100 cycles
    send("bp", 1'b0, 7'd32, 64'h0);
    get_rsp("bp", 37, r);
    check("bp_data", r, {32'h0, IDCODE});
    unstable = 0;
    start    = rise_cnt;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_data !== r || cmd_ready || tck || tms) unstable++;
    end
    check("bp_stable", unstable, 0);
    check("bp_no_tck", rise_cnt - start, 0);

    // Command presented in the same cycle as rsp_ready: taken only in the next IDLE cycle
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_is_ir = 1'b0;
    cmd_len   = 7'd0;
    cmd_data  = '0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp_rsp_drop", rsp_valid, 1'b0);
    check("bp_ready_back", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rise0     = rise_cnt;
    check("late_cmd_taken", cmd_ready, 1'b0);
    get_rsp("late_cmd", 6, r);
    check("late_cmd_data", r, 64'h0);
    ack("late_cmd");

    // Reset pulse while a 64-bit DR scan is shifting with TCK high
    send("abort", 1'b0, 7'd64, 64'hFFFF_0000_AAAA_5555);
    waitc = 0;
    while (!((rise_cnt - rise0) >= 10 && tck) && waitc < 1000) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("abort_in_shift", tap_q, SH_DR);
    check("abort_tck_high", tck, 1'b1);
    reset_n = 1'b0;
    #1;
    check("abort_tck", tck, 1'b0);
    check("abort_tms", tms, 1'b1);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_busy", busy, 1'b1);
    check("abort_rsp_data", rsp_data, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_init("reinit");

    scan("idcode2", 1'b0, 7'd32, 64'h0, 37, {32'h0, IDCODE});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
